// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit counters plus E-stage mispredict detection.
// Optional return-address stack is compiled in when BP_RAS_EN is defined.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic [31:0] InstrF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        ValidE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        TakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] PCPlus4E,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    input  logic [4:0]  RdE,
    input  logic [4:0]  Rs1E,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic               isjump_q [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_f;
    logic             hit_e;
    logic             btb_taken_f;
    logic [31:0]      pc_plus4_f;

    assign idx_f      = PCF[IDX_W+1:2];
    assign tag_f      = PCF[31:IDX_W+2];
    assign idx_e      = PCE[IDX_W+1:2];
    assign tag_e      = PCE[31:IDX_W+2];
    assign pc_plus4_f = PCF + 32'd4;

    // Lookup reads pre-update contents; a same-cycle write is seen next cycle.
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign btb_taken_f = hit_f && (isjump_q[idx_f] || ctr_q[idx_f][1]);

    logic       update_e;
    logic       alias_e;
    logic       taken_eff_e;
    logic       alloc_e;
    logic       tgt_we_e;
    logic       ctr_we_e;
    logic [1:0] ctr_d;

    assign update_e    = ValidE && (BranchE || JumpE);
    assign alias_e     = ValidE && PredTakenE && !BranchE && !JumpE;
    assign taken_eff_e = TakenE && !alias_e;

    assign MispredictE = ValidE && ((taken_eff_e != PredTakenE) ||
                                    (taken_eff_e && (PredTargetE != PCTargetE)));
    assign RedirectPCE = taken_eff_e ? PCTargetE : PCPlus4E;

    always_comb begin
        alloc_e  = 1'b0;
        tgt_we_e = 1'b0;
        ctr_we_e = 1'b0;
        ctr_d    = ctr_q[idx_e];
        if (update_e) begin
            if (TakenE && !hit_e) begin
                alloc_e  = 1'b1;
                tgt_we_e = 1'b1;
                ctr_we_e = 1'b1;
                ctr_d    = 2'd2;
            end else if (TakenE) begin
                tgt_we_e = 1'b1;
                ctr_we_e = 1'b1;
                ctr_d    = (ctr_q[idx_e] == 2'd3) ? 2'd3 : ctr_q[idx_e] + 2'd1;
            end else if (hit_e) begin
                ctr_we_e = 1'b1;
                ctr_d    = (ctr_q[idx_e] == 2'd0) ? 2'd0 : ctr_q[idx_e] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'd0;
            end
        end else begin
            if (alloc_e) begin
                valid_q[idx_e] <= 1'b1;
            end else if (alias_e) begin
                valid_q[idx_e] <= 1'b0;
            end
            if (ctr_we_e) begin
                ctr_q[idx_e] <= ctr_d;
            end
        end
    end

    // Tag/target/type storage is qualified by valid, so it is left unreset.
    always_ff @(posedge clk) begin
        if (tgt_we_e) begin
            target_q[idx_e] <= PCTargetE;
        end
        if (alloc_e) begin
            tag_q[idx_e]    <= tag_e;
            isjump_q[idx_e] <= JumpE;
        end
    end

`ifdef BP_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]      ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] ras_widx;
    logic             ras_we;
    logic             push_e;
    logic             pop_e;
    logic             is_ret_f;
    logic             ras_hit_f;

    // ptr_q is the next free slot; the top lives one slot below, wrapping.
    assign top_idx  = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - 1'b1;
    assign next_ptr = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;

    assign push_e = ValidE && JumpE && ((RdE == 5'd1) || (RdE == 5'd5));
    assign pop_e  = ValidE && JumpE && (RdE == 5'd0) &&
                    ((Rs1E == 5'd1) || (Rs1E == 5'd5));

    assign is_ret_f  = (InstrF[6:0] == 7'b1100111) && (InstrF[14:12] == 3'b000) &&
                       (InstrF[11:7] == 5'd0) &&
                       ((InstrF[19:15] == 5'd1) || (InstrF[19:15] == 5'd5));
    assign ras_hit_f = is_ret_f && (cnt_q != '0);

    always_comb begin
        ras_we   = 1'b0;
        ras_widx = ptr_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        if (push_e && pop_e && (cnt_q != '0)) begin
            ras_we   = 1'b1;
            ras_widx = top_idx;
        end else if (push_e) begin
            ras_we   = 1'b1;
            ras_widx = ptr_q;
            ptr_d    = next_ptr;
            cnt_d    = (cnt_q == CNT_W'(RAS_DEPTH)) ? cnt_q : cnt_q + 1'b1;
        end else if (pop_e && (cnt_q != '0)) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_widx] <= PCPlus4E;
        end
    end

    assign PredTakenF  = ras_hit_f || btb_taken_f;
    assign PredTargetF = ras_hit_f   ? ras_q[top_idx] :
                         btb_taken_f ? target_q[idx_f] : pc_plus4_f;

    logic unused_ok;
    assign unused_ok = ^{PCE[1:0]};
`else
    localparam int unused_ras_depth = RAS_DEPTH;

    assign PredTakenF  = btb_taken_f;
    assign PredTargetF = btb_taken_f ? target_q[idx_f] : pc_plus4_f;

    logic unused_ok;
    assign unused_ok = ^{InstrF, RdE, Rs1E, PCE[1:0]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios, then random
// traffic compared against an array/queue reference model.
module tb_branch_predictor;

    localparam int ENTRIES   = 16;
    localparam int RAS_DEPTH = 4;
    localparam logic [31:0] RET_INSTR = 32'h0000_8067;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, InstrF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        ValidE, BranchE, JumpE, TakenE;
    logic [31:0] PCE, PCTargetE, PCPlus4E;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic [4:0]  RdE, Rs1E;
    logic        MispredictE;
    logic [31:0] RedirectPCE;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .InstrF(InstrF),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .ValidE(ValidE), .BranchE(BranchE), .JumpE(JumpE), .TakenE(TakenE),
        .PCE(PCE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .RdE(RdE), .Rs1E(Rs1E),
        .MispredictE(MispredictE), .RedirectPCE(RedirectPCE)
    );

    always #5 clk = ~clk;

    // Reference model: one record per table slot, RAS as a bounded queue.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    bit          m_isjump [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_ras[$];

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 0;
        end
        m_ras.delete();
    endfunction

    function automatic bit is_return(input logic [31:0] instr);
        int unsigned op, f3, rd, rs1;
        op  = instr % 128;
        rd  = (instr / 128) % 32;
        f3  = (instr / 4096) % 8;
        rs1 = (instr / 32768) % 32;
        return (op == 'h67) && (f3 == 0) && (rd == 0) && (rs1 == 1 || rs1 == 5);
    endfunction

    function automatic void model_predict(input logic [31:0] pc, input logic [31:0] instr,
                                          output bit tk, output logic [31:0] tg);
        int          idx;
        int unsigned tagv;
        idx  = (pc / 4) % ENTRIES;
        tagv = pc / (4 * ENTRIES);
        tk   = 0;
        tg   = pc + 32'd4;
        if (m_valid[idx] && m_tag[idx] == tagv && (m_isjump[idx] || m_ctr[idx] >= 2)) begin
            tk = 1;
            tg = m_target[idx];
        end
`ifdef BP_RAS_EN
        if (is_return(instr) && m_ras.size() > 0) begin
            tk = 1;
            tg = m_ras[$];
        end
`endif
    endfunction

    function automatic void model_update();
        int          idx;
        int unsigned tagv;
        bit          hit;
        if (!rst) begin
            model_reset();
            return;
        end
        idx  = (PCE / 4) % ENTRIES;
        tagv = PCE / (4 * ENTRIES);
        hit  = m_valid[idx] && m_tag[idx] == tagv;
        if (ValidE && (BranchE || JumpE)) begin
            if (TakenE && !hit) begin
                m_valid[idx]  = 1;
                m_tag[idx]    = tagv;
                m_target[idx] = PCTargetE;
                m_isjump[idx] = JumpE;
                m_ctr[idx]    = 2;
            end else if (TakenE) begin
                m_target[idx] = PCTargetE;
                if (m_ctr[idx] < 3) m_ctr[idx]++;
            end else if (hit) begin
                if (m_ctr[idx] > 0) m_ctr[idx]--;
            end
        end else if (ValidE && PredTakenE) begin
            m_valid[idx] = 0;
        end
`ifdef BP_RAS_EN
        if (ValidE && JumpE && (RdE == 1 || RdE == 5)) begin
            m_ras.push_back(PCPlus4E);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (ValidE && JumpE && RdE == 0 && (Rs1E == 1 || Rs1E == 5)) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
        end
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic check_model(input string tag);
        bit          tk, t_eff, mis;
        logic [31:0] tg;
        model_predict(PCF, InstrF, tk, tg);
        check({tag, ".pred_taken"}, {31'd0, PredTakenF}, {31'd0, tk});
        check({tag, ".pred_target"}, PredTargetF, tg);
        t_eff = (ValidE && PredTakenE && !BranchE && !JumpE) ? 1'b0 : TakenE;
        mis   = ValidE && ((t_eff != PredTakenE) || (t_eff && PredTargetE != PCTargetE));
        check({tag, ".mispredict"}, {31'd0, MispredictE}, {31'd0, mis});
        if (mis) check({tag, ".redirect"}, RedirectPCE, t_eff ? PCTargetE : PCPlus4E);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_e(input bit v, input bit br, input bit jp, input bit tk,
                           input logic [31:0] pce, input logic [31:0] tgt,
                           input bit ptk, input logic [31:0] ptgt,
                           input logic [4:0] rd, input logic [4:0] rs1);
        ValidE      = v;
        BranchE     = br;
        JumpE       = jp;
        TakenE      = tk;
        PCE         = pce;
        PCTargetE   = tgt;
        PCPlus4E    = pce + 32'd4;
        PredTakenE  = ptk;
        PredTargetE = ptgt;
        RdE         = rd;
        Rs1E        = rs1;
        #1;
    endtask

    task automatic idle_e();
        drive_e(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 5'd0, 5'd0);
    endtask

    initial begin
        bit          ptk;
        logic [31:0] ptgt;
        logic [31:0] pce;
        int          kind;

        // Reset: outputs fall back to PCF+4 while held.
        rst    = 1'b0;
        PCF    = 32'h40;
        InstrF = NOP_INSTR;
        idle_e();
        model_reset();
        check("rst_hold.pred_taken", {31'd0, PredTakenF}, 32'd0);
        check("rst_hold.pred_target", PredTargetF, 32'h44);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("after_rst.pred_taken", {31'd0, PredTakenF}, 32'd0);
        check("after_rst.pred_target", PredTargetF, 32'h44);

        // First taken resolution of branch 0x40 -> 0x80.
        drive_e(1, 1, 0, 1, 32'h40, 32'h80, 0, 32'h44, 5'd0, 5'd0);
        check("first_taken.mispredict", {31'd0, MispredictE}, 32'd1);
        check("first_taken.redirect", RedirectPCE, 32'h80);
        check_model("first_taken");
        tick();
        idle_e();
        check("learned.pred_taken", {31'd0, PredTakenF}, 32'd1);
        check("learned.pred_target", PredTargetF, 32'h80);

        // Counter walk 2 -> 3 -> 2 -> 1.
        drive_e(1, 1, 0, 1, 32'h40, 32'h80, 1, 32'h80, 5'd0, 5'd0);
        check("second_taken.mispredict", {31'd0, MispredictE}, 32'd0);
        tick();
        drive_e(1, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80, 5'd0, 5'd0);
        check("nt1.mispredict", {31'd0, MispredictE}, 32'd1);
        check("nt1.redirect", RedirectPCE, 32'h44);
        tick();
        idle_e();
        check("ctr2.pred_taken", {31'd0, PredTakenF}, 32'd1);
        drive_e(1, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80, 5'd0, 5'd0);
        check("nt2.mispredict", {31'd0, MispredictE}, 32'd1);
        check("nt2.redirect", RedirectPCE, 32'h44);
        tick();
        idle_e();
        check("ctr1.pred_taken", {31'd0, PredTakenF}, 32'd0);
        check("ctr1.pred_target", PredTargetF, 32'h44);

        // Aliasing: same index, different tag, then a non-branch alias.
        drive_e(1, 1, 0, 1, 32'h40, 32'h80, 0, 32'h44, 5'd0, 5'd0);
        tick();
        idle_e();
        PCF = 32'h440;
        #1;
        check("alias_lookup.pred_taken", {31'd0, PredTakenF}, 32'd0);
        check("alias_lookup.pred_target", PredTargetF, 32'h444);
        PCF = 32'h40;
        drive_e(1, 0, 0, 0, 32'h40, 32'h0, 1, 32'h80, 5'd0, 5'd0);
        check("alias_e.mispredict", {31'd0, MispredictE}, 32'd1);
        check("alias_e.redirect", RedirectPCE, 32'h44);
        tick();
        idle_e();
        check("alias_clear.pred_taken", {31'd0, PredTakenF}, 32'd0);

        // ValidE low: no mispredict and no table change.
        drive_e(0, 1, 0, 1, 32'h200, 32'h300, 0, 32'h204, 5'd0, 5'd0);
        check("invalid_e.mispredict", {31'd0, MispredictE}, 32'd0);
        tick();
        idle_e();
        PCF = 32'h200;
        #1;
        check("invalid_e.pred_taken", {31'd0, PredTakenF}, 32'd0);

        // Same-cycle lookup and update of one index sees old contents.
        drive_e(1, 1, 0, 1, 32'h200, 32'h300, 0, 32'h204, 5'd0, 5'd0);
        check("no_bypass.pred_taken", {31'd0, PredTakenF}, 32'd0);
        tick();
        idle_e();
        check("post_update.pred_target", PredTargetF, 32'h300);

        // Mid-run reset empties the predictor immediately.
        rst = 1'b0;
        #1;
        model_reset();
        check("mid_rst.pred_taken", {31'd0, PredTakenF}, 32'd0);
        check("mid_rst.pred_target", PredTargetF, 32'h204);
        tick();
        rst = 1'b1;
        tick();
        check("resume.pred_taken", {31'd0, PredTakenF}, 32'd0);

`ifdef BP_RAS_EN
        // Call at 0x100 pushes 0x104; a return in fetch predicts it.
        drive_e(1, 0, 1, 1, 32'h100, 32'h400, 0, 32'h104, 5'd1, 5'd0);
        tick();
        idle_e();
        PCF    = 32'h500;
        InstrF = RET_INSTR;
        #1;
        check("ras_ret.pred_taken", {31'd0, PredTakenF}, 32'd1);
        check("ras_ret.pred_target", PredTargetF, 32'h104);
        for (int k = 0; k <= RAS_DEPTH; k++) begin
            drive_e(1, 0, 1, 1, 32'h1000 + k * 32'h10, 32'h400, 0, 32'h0,
                    (k % 2 == 0) ? 5'd1 : 5'd5, 5'd0);
            tick();
        end
        idle_e();
        for (int j = 0; j < RAS_DEPTH; j++) begin
            check("ras_pop.pred_target", PredTargetF, 32'h1004 + (RAS_DEPTH - j) * 32'h10);
            check_model("ras_pop");
            drive_e(1, 0, 1, 1, 32'h2000, 32'h3000, 1, 32'h3000, 5'd0, 5'd1);
            tick();
        end
        idle_e();
        check("ras_empty.pred_taken", {31'd0, PredTakenF}, 32'd0);
        InstrF = NOP_INSTR;
`endif

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            PCF    = ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
            InstrF = ($urandom_range(0, 3) == 0) ? RET_INSTR : NOP_INSTR;
            pce    = ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 1) == 1) begin
                model_predict(pce, NOP_INSTR, ptk, ptgt);
            end else begin
                ptk  = $urandom_range(0, 1);
                ptgt = $urandom & 32'hFFFF_FFFC;
            end
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) begin
                drive_e(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                        pce, $urandom & 32'hFFFF_FFFC, ptk, ptgt, 5'd1, 5'd1);
            end else if (kind < 5) begin
                drive_e(1, 1, 0, $urandom_range(0, 1), pce,
                        ($urandom_range(0, 1) == 1) ? ptgt : ($urandom & 32'hFFFF_FFFC),
                        ptk, ptgt, 5'd0, 5'd0);
            end else if (kind < 7) begin
                drive_e(1, 0, 1, 1, pce, $urandom & 32'hFFFF_FFFC, ptk, ptgt,
                        ($urandom_range(0, 2) == 0) ? 5'd0 : ($urandom_range(0, 1) ? 5'd1 : 5'd5),
                        $urandom_range(0, 1) ? 5'd1 : 5'd5);
            end else if (kind == 7) begin
                drive_e(1, 0, 0, 0, pce, 32'h0, 1, ptgt, 5'd0, 5'd0);
            end else begin
                drive_e(1, 0, 0, 0, pce, 32'h0, 0, ptgt, 5'd0, 5'd0);
            end
            check_model("random");
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_model("random_rst");
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of BTB entries; SHALL be a power of two, from 4 to 256.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack depth; used only when BP_RAS_EN is defined.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 PCF  input  32  fetch-stage PC used for lookup.
REQ-006 InstrF  input  32  fetch-stage instruction, used for return predecode.
REQ-007 PredTakenF  output  1  prediction: fetch from PredTargetF next.
REQ-008 PredTargetF  output  32  predicted next PC.
REQ-009 ValidE  input  1  E-stage holds a real (non-flushed) instruction.
REQ-010 BranchE, JumpE  input  1 each  E-stage control-flow type.
REQ-011 TakenE  input  1  resolved outcome (PCSrcE).
REQ-012 PCE, PCTargetE, PCPlus4E  input  32 each  resolved PC values.
REQ-013 PredTakenE, PredTargetE  input  1/32  the fetch prediction, carried down the pipeline.
REQ-014 RdE, Rs1E  input  5 each  E-stage register fields, used to classify calls and returns.
REQ-015 MispredictE  output  1  flush-and-redirect request.
REQ-016 RedirectPCE  output  32  correct next PC when MispredictE is high.

Function
REQ-017 Index SHALL be PC[IDX_W+1:2], with IDX_W = log2(ENTRIES); tag SHALL be PC[31:IDX_W+2].
REQ-018 Each entry SHALL hold: valid, tag, 32-bit target, IsJump bit, and a 2-bit saturating counter.
REQ-019 Lookup SHALL be combinational from PCF.
REQ-020 A hit SHALL require valid AND tag match.
REQ-021 PredTakenF SHALL equal hit AND (IsJump OR counter >= 2); PredTargetF SHALL be the stored target when PredTakenF is high, else PCF+4.
REQ-022 An update SHALL occur when ValidE AND (BranchE OR JumpE); it is written at the next edge.
REQ-023 Update, taken, miss: allocate the entry with tag, target = PCTargetE, IsJump = JumpE, counter = 2.
REQ-024 Update, taken, hit: write the target; increment the counter, saturating at 3.
REQ-025 Update, not taken, hit: decrement the counter, saturating at 0.
REQ-026 Update, not taken, miss: no change.
REQ-027 ValidE high with PredTakenE high but neither BranchE nor JumpE (alias): clear that entry's valid bit.
REQ-028 MispredictE SHALL equal ValidE AND ((TakenE != PredTakenE) OR (TakenE AND PredTargetE != PCTargetE)).
REQ-029 The alias case in REQ-027 SHALL treat TakenE as 0.
REQ-030 RedirectPCE SHALL be PCTargetE if TakenE, else PCPlus4E.
REQ-031 MispredictE SHALL be 0 when ValidE is low, regardless of other inputs.
REQ-032 Simultaneous lookup and update of the same index: lookup SHALL return pre-update contents; there is no bypass.
REQ-033 Latency: prediction is available in the same cycle; a BTB update is visible to lookups from the next cycle.

Reset
REQ-034 rst low SHALL immediately clear all valid bits, all counters to 0, and the RAS pointer and count to 0.
REQ-035 While rst is low, PredTakenF SHALL be 0 and PredTargetF SHALL be PCF+4.
REQ-036 Target and tag contents need not be cleared.
REQ-037 Deasserting rst mid-operation SHALL resume from an empty predictor.

Configuration
REQ-038 Macro BP_RAS_EN SHALL control the return-address stack.
REQ-039 With BP_RAS_EN defined, a RAS of RAS_DEPTH entries SHALL be updated at E:
- Push PCPlus4E when ValidE, JumpE, and RdE is x1 or x5 (call).
- Pop when ValidE, JumpE, RdE = x0, and Rs1E is x1 or x5 (return).
- Simultaneous push and pop SHALL replace the top entry.
- Push when full SHALL overwrite the oldest entry (circular); pop when empty SHALL be ignored.
REQ-040 With BP_RAS_EN defined, if InstrF decodes as JALR with rd = x0, rs1 in {x1, x5}, and the RAS is non-empty, then PredTakenF SHALL be 1 and PredTargetF SHALL be the RAS top; this overrides the BTB.
REQ-041 Without BP_RAS_EN, no RAS logic SHALL exist, RAS_DEPTH is ignored, and prediction is BTB-only.

Verification
REQ-042 Reset, then PCF=0x40: PredTakenF=0, PredTargetF=0x44.
REQ-043 Taken branch PCE=0x40 to 0x80 resolved once, then PCF=0x40: PredTakenF=1, PredTargetF=0x80; the first resolution gave MispredictE=1, RedirectPCE=0x80.
REQ-044 Same branch taken twice, then not taken: counter 3 then 2, still predicted taken. A second not-taken gives counter 1 and PredTakenF=0; each not-taken gives MispredictE=1 with RedirectPCE=PCPlus4E.
REQ-045 ENTRIES=16 aliasing: entry at 0x40, lookup of 0x440 (same index, different tag) gives PredTakenF=0. A non-branch at 0x40 arriving with PredTakenE=1 gives MispredictE=1, RedirectPCE=0x44, and the entry invalidated.
REQ-046 BP_RAS_EN: call at PCE=0x100 (JAL, rd=x1) pushes 0x104; then InstrF=0x00008067 gives PredTakenF=1, PredTargetF=0x104. A RAS_DEPTH+1 call sequence overwrites the oldest entry.
REQ-047 ValidE=0 with TakenE=1 and PredTakenE=0: MispredictE=0 and no table change.
